generador22_numeros6bit: RTL and testbench
==========================================

# generador22_numeros6bit

Sequential source that emits, one per handshake, the 22 six-bit values accepted by the 22-number 6-bit comparator: 1, 2, 3, 5, 10, 12, 13, 15, 20, 21, 22, 23, 25, 30, 31, 33, 35, 36, 50, 51, 52, 53. It is the transmitting end of the comparator path. It drives a valid/ready stream into the comparator, or into any consumer of member values, for stimulus generation and exhaustive self-check of the membership datapath.

## Interface
Parameters:
- DESCENDENTE, default 0: 0 emits in ascending order (1 … 53); 1 emits in descending order (53 … 1).

Ports:
- Reloj  input  1  system clock, all state on rising edge.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- Inicio  input  1  start request; sampled only in REPOSO.
- Ciclico  input  1  sampled with Inicio; 1 means wrap to the first member after the last, 0 means a single pass.
- Abortar  input  1  synchronous abort; takes priority over all other inputs except Reset.
- Listo  input  1  downstream ready.
- Salida  output  6  current member value.
- Valido  output  1  Salida holds a member awaiting transfer.
- Indice  output  5  position of Salida in emission order, 0…21.
- Ultimo  output  1  Salida is the last member of the pass (Indice == 21).
- Hecho  output  1  one-cycle pulse after the final transfer of a single pass.
- Error  output  1  sticky self-check flag; present only with the macro (see Configuration).

## Operation
- States:
  - REPOSO, reset state.
  - EMITE.
- REPOSO:
  - Valido=0 and Indice=0.
  - Inicio=1 → EMITE. Ciclico is latched into modo_ciclico. Indice=0.
- EMITE:
  - Valido=1 and Salida=tabla(Indice).
  - Transfer occurs when Valido & Listo.
  - Transfer with Indice<21 → Indice+1.
  - Transfer with Indice==21 and modo_ciclico=1 → Indice=0 on the next cycle, with no bubble.
  - Transfer with Indice==21 and modo_ciclico=0 → REPOSO, and Hecho=1 for one cycle.
- Abortar=1 in any state → REPOSO next cycle, with Valido=0, Indice=0, no Hecho, and modo_ciclico cleared.
- Inicio while in EMITE is ignored. Ciclico changes after the start are ignored.
- Simultaneous Abortar and Inicio in REPOSO: Abortar wins, and the state stays REPOSO.
- Simultaneous Abortar and a transfer: the transfer counts at the consumer, but the state goes to REPOSO.
- Index arithmetic: 5-bit unsigned. Values 22–31 are unreachable. If reached, they force REPOSO on the next cycle.
- DESCENDENTE=1: Salida=tabla(21−Indice). Indice, Ultimo and Hecho semantics are unchanged.

## Timing
- Reset values:
  - Salida = tabla(0) under the active order (1 ascending, 53 descending).
  - Valido=0, Indice=0, Ultimo=0, Hecho=0, Error=0.
- Start latency: Inicio sampled high at edge N gives Valido=1 with the first member after edge N.
- Throughput: with Listo held high, one member per cycle. A single pass takes 22 cycles, and Hecho is high in cycle 23.
- Backpressure: while Valido=1 and Listo=0, Salida, Indice and Ultimo hold stable.
- Valido never drops without a transfer, except on Abortar or Reset.
- Salida, Valido, Indice and Ultimo are registered or derived from registered state only. No input-to-output combinational path, including Listo to Valido.
- Reset mid-pass: outputs return to reset values asynchronously. Hecho is not generated.

## Configuration
- Macro GENERADOR22_AUTOCHEQUEO_EN.
- Defined:
  - An internal membership check evaluates Salida whenever Valido=1.
  - The check uses the same nibble-group decoding as the comparator (Salida[5:4] selects the group, Salida[3:0] is matched within it).
  - Any non-member sets Error=1 on the next edge. Error stays set until Reset.
- Not defined: no check logic, and the Error port is absent.

## Structure
- Package generador22_pkg:
  - N_MIEMBROS=22.
  - ANCHO=6.
  - State enum {REPOSO, EMITE}.
  - 22-entry constant table of members in ascending order.
- Sub-module generador22_tabla: combinational index→value lookup with a 5-bit input and 6-bit output. Out-of-range indices return 0.
- With the macro, the checker is a second combinational instance and has no separate state.

## Test plan
- Reset, then Inicio=1 with Ciclico=0 and Listo=1 for 24 cycles → Salida sequence 1,2,3,5,…,52,53; Ultimo only with 53; Hecho is a single pulse in cycle 23; Valido=0 afterwards.
- Listo toggled at random during a pass → every value appears exactly once and in order; Salida is stable during every stall.
- Ciclico=1 with Listo=1 for 50 cycles → 53 is followed directly by 1, with no gap; Hecho is never asserted.
- Abortar at Indice=7 (Salida=15) → next cycle Valido=0 and Indice=0; a new Inicio restarts at 1.
- DESCENDENTE=1, one pass → 53,52,51,50,36,…,2,1; Ultimo with 1.
- With GENERADOR22_AUTOCHEQUEO_EN, force the table entry at Indice=4 to 11 → Error=1 one cycle after that entry is valid, and it stays set until Reset.

Source files
------------

// File: rtl/generador22_pkg.sv
// ----------------------------------------------------------------------------
// generador22_pkg
// Shared constants for the 22-member six-bit value generator:
//   N_MIEMBROS    number of members emitted per pass (22)
//   ANCHO         width of a member value (6)
//   ULTIMO_IDX    index of the last member of a pass (21)
//   estado_t      generator states {REPOSO, EMITE}
//   TABLA         members in ascending order
//   MASCARA_GRUPO membership masks, one 16-bit mask per upper-two-bit group,
//                 bit n set when {group, n} is a member
// ----------------------------------------------------------------------------
package generador22_pkg;

    localparam int N_MIEMBROS = 22;
    localparam int ANCHO      = 6;

    localparam logic [4:0] ULTIMO_IDX = 5'd21;

    typedef enum logic {
        REPOSO = 1'b0,
        EMITE  = 1'b1
    } estado_t;

    typedef logic [ANCHO-1:0] tabla_t [N_MIEMBROS];

    localparam tabla_t TABLA = '{
        6'd1,  6'd2,  6'd3,  6'd5,  6'd10, 6'd12, 6'd13, 6'd15,
        6'd20, 6'd21, 6'd22, 6'd23, 6'd25, 6'd30, 6'd31, 6'd33,
        6'd35, 6'd36, 6'd50, 6'd51, 6'd52, 6'd53
    };

    typedef logic [15:0] mascara_t [4];

    // Group 0: 1,2,3,5,10,12,13,15   Group 1: 20..23,25,30,31
    // Group 2: 33,35,36              Group 3: 50..53
    localparam mascara_t MASCARA_GRUPO = '{
        16'hB42E,
        16'hC2F0,
        16'h001A,
        16'h003C
    };

endpackage

// File: rtl/generador22_tabla.sv
// ----------------------------------------------------------------------------
// generador22_tabla
// Combinational index-to-member lookup.
//   indice_i  [4:0]  position in ascending order
//   valor_o   [5:0]  member at that position, 0 for indices 22..31
//
// generador22_chequeo
// Combinational membership test using the comparator's nibble-group decoding.
//   valor_i   [5:0]  value under test
//   miembro_o        1 when valor_i is one of the 22 members
// ----------------------------------------------------------------------------
module generador22_tabla
    import generador22_pkg::*;
(
    input  logic [4:0]       indice_i,
    output logic [ANCHO-1:0] valor_o
);

    always_comb begin
        valor_o = '0;
        if (indice_i < 5'(N_MIEMBROS)) begin
            valor_o = TABLA[indice_i];
        end
    end

endmodule

module generador22_chequeo
    import generador22_pkg::*;
(
    input  logic [ANCHO-1:0] valor_i,
    output logic             miembro_o
);

    // Upper two bits pick the group mask, lower nibble picks the bit inside it.
    always_comb begin
        miembro_o = MASCARA_GRUPO[valor_i[5:4]][valor_i[3:0]];
    end

endmodule

// File: rtl/generador22_numeros6bit.sv
// ----------------------------------------------------------------------------
// generador22_numeros6bit
// Emits the 22 comparator members as a valid/ready stream, one per transfer.
//
// Parameter:
//   DESCENDENTE  0 = ascending order (1..53), 1 = descending order (53..1)
// Ports:
//   Reloj    clock, rising edge
//   Reset    asynchronous active-high reset
//   Inicio   start request, sampled in REPOSO only
//   Ciclico  sampled with Inicio: 1 wraps after the last member, 0 = one pass
//   Abortar  synchronous abort, highest priority after Reset
//   Listo    downstream ready
//   Salida   current member value
//   Valido   Salida is waiting to be transferred
//   Indice   position of Salida in emission order, 0..21
//   Ultimo   Salida is the last member of the pass
//   Hecho    one-cycle pulse after the final transfer of a single pass
//   Error    sticky non-member flag (only with GENERADOR22_AUTOCHEQUEO_EN)
//
// Macro GENERADOR22_AUTOCHEQUEO_EN adds the membership self-check and Error.
// ----------------------------------------------------------------------------
module generador22_numeros6bit
    import generador22_pkg::*;
#(
    parameter bit DESCENDENTE = 1'b0
)
(
    input  logic             Reloj,
    input  logic             Reset,
    input  logic             Inicio,
    input  logic             Ciclico,
    input  logic             Abortar,
    input  logic             Listo,
    output logic [ANCHO-1:0] Salida,
    output logic             Valido,
    output logic [4:0]       Indice,
    output logic             Ultimo,
    output logic             Hecho
`ifdef GENERADOR22_AUTOCHEQUEO_EN
    ,
    output logic             Error
`endif
);

    estado_t          estado_q;
    logic [4:0]       indice_q;
    logic             modoCiclico_q;
    logic             hecho_q;
    logic [4:0]       indiceTabla_d;
    logic [ANCHO-1:0] salidaTabla;

    // Descending order reads the same ascending table from the far end, so
    // Indice keeps counting up in both orders.
    assign indiceTabla_d = DESCENDENTE ? (ULTIMO_IDX - indice_q) : indice_q;

    generador22_tabla u_tabla (
        .indice_i (indiceTabla_d),
        .valor_o  (salidaTabla)
    );

    // Control FSM. indice_q is kept at 0 whenever the state is REPOSO, so the
    // idle Salida is always the first member of the active order.
    always_ff @(posedge Reloj or posedge Reset) begin
        if (Reset) begin
            estado_q      <= REPOSO;
            indice_q      <= '0;
            modoCiclico_q <= 1'b0;
            hecho_q       <= 1'b0;
        end else begin
            hecho_q <= 1'b0;
            if (Abortar) begin
                estado_q      <= REPOSO;
                indice_q      <= '0;
                modoCiclico_q <= 1'b0;
            end else begin
                case (estado_q)
                    REPOSO: begin
                        indice_q <= '0;
                        if (Inicio) begin
                            estado_q      <= EMITE;
                            modoCiclico_q <= Ciclico;
                        end
                    end
                    EMITE: begin
                        if (indice_q > ULTIMO_IDX) begin
                            // Unreachable index: recover to idle.
                            estado_q      <= REPOSO;
                            indice_q      <= '0;
                            modoCiclico_q <= 1'b0;
                        end else if (Listo) begin
                            if (indice_q == ULTIMO_IDX) begin
                                indice_q <= '0;
                                if (!modoCiclico_q) begin
                                    estado_q <= REPOSO;
                                    hecho_q  <= 1'b1;
                                end
                            end else begin
                                indice_q <= indice_q + 5'd1;
                            end
                        end
                    end
                    default: begin
                        estado_q      <= REPOSO;
                        indice_q      <= '0;
                        modoCiclico_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Valido = (estado_q == EMITE);
    assign Salida = salidaTabla;
    assign Indice = indice_q;
    assign Ultimo = Valido && (indice_q == ULTIMO_IDX);
    assign Hecho  = hecho_q;

`ifdef GENERADOR22_AUTOCHEQUEO_EN
    logic miembro;
    logic error_q;

    generador22_chequeo u_chequeo (
        .valor_i   (Salida),
        .miembro_o (miembro)
    );

    // Sticky flag: once any non-member is offered, it stays set until Reset.
    always_ff @(posedge Reloj or posedge Reset) begin
        if (Reset) begin
            error_q <= 1'b0;
        end else if (Valido && !miembro) begin
            error_q <= 1'b1;
        end
    end

    assign Error = error_q;
`endif

endmodule

// File: tb/tb_generador22_numeros6bit.sv
// ----------------------------------------------------------------------------
// tb_generador22_numeros6bit
// Drives an ascending and a descending generator from the same inputs and
// compares their streams against an independent list of the 22 members.
// ----------------------------------------------------------------------------
module tb_generador22_numeros6bit;

    logic       Reloj = 1'b0;
    logic       Reset;
    logic       Inicio;
    logic       Ciclico;
    logic       Abortar;
    logic       Listo;
    logic [5:0] salA, salD;
    logic       valA, valD;
    logic [4:0] idxA, idxD;
    logic       ultA, ultD;
    logic       hechoA, hechoD;
`ifdef GENERADOR22_AUTOCHEQUEO_EN
    logic       errA, errD;
`endif

    int miembros [22] = '{1, 2, 3, 5, 10, 12, 13, 15, 20, 21, 22,
                          23, 25, 30, 31, 33, 35, 36, 50, 51, 52, 53};

    typedef struct {
        int salida;
        int indice;
    } esperado_t;

    esperado_t qA [$];
    esperado_t qD [$];

    int totalChecks  = 0;
    int passedChecks = 0;

    generador22_numeros6bit #(.DESCENDENTE(1'b0)) dut (
`ifdef GENERADOR22_AUTOCHEQUEO_EN
        .Error   (errA),
`endif
        .Reloj   (Reloj),
        .Reset   (Reset),
        .Inicio  (Inicio),
        .Ciclico (Ciclico),
        .Abortar (Abortar),
        .Listo   (Listo),
        .Salida  (salA),
        .Valido  (valA),
        .Indice  (idxA),
        .Ultimo  (ultA),
        .Hecho   (hechoA)
    );

    generador22_numeros6bit #(.DESCENDENTE(1'b1)) dutDesc (
`ifdef GENERADOR22_AUTOCHEQUEO_EN
        .Error   (errD),
`endif
        .Reloj   (Reloj),
        .Reset   (Reset),
        .Inicio  (Inicio),
        .Ciclico (Ciclico),
        .Abortar (Abortar),
        .Listo   (Listo),
        .Salida  (salD),
        .Valido  (valD),
        .Indice  (idxD),
        .Ultimo  (ultD),
        .Hecho   (hechoD)
    );

    // 100 MHz clock.
    always #5 Reloj = ~Reloj;

    // Hard stop in case something never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string nombre, input int actual, input int esperado);
        totalChecks++;
        if (actual == esperado) begin
            passedChecks++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", nombre, actual, esperado);
        end
    endtask

    task automatic applyStimulus(input bit inicio, input bit ciclico, input bit abortar, input bit listo);
        Inicio  = inicio;
        Ciclico = ciclico;
        Abortar = abortar;
        Listo   = listo;
    endtask

    // Advance to just after the next rising edge.
    task automatic stepCycle();
        @(posedge Reloj);
        #1;
    endtask

    // Expected transfers of n members, wrapping after the last one.
    task automatic pushPass(input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            k = i % 22;
            qA.push_back('{miembros[k], k});
            qD.push_back('{miembros[21 - k], k});
        end
    endtask

    // Called with the inputs for the coming edge already applied: a transfer
    // happens at that edge when Valido and Listo are both high.
    task automatic observe();
        esperado_t e;
        if (valA && Listo) begin
            if (qA.size() == 0) begin
                checkOutput("unexpected transfer asc", 1, 0);
            end else begin
                e = qA.pop_front();
                checkOutput("salida asc", int'(salA), e.salida);
                checkOutput("indice asc", int'(idxA), e.indice);
                checkOutput("ultimo asc", int'(ultA), int'(e.indice == 21));
            end
        end
        if (valD && Listo) begin
            if (qD.size() == 0) begin
                checkOutput("unexpected transfer desc", 1, 0);
            end else begin
                e = qD.pop_front();
                checkOutput("salida desc", int'(salD), e.salida);
                checkOutput("indice desc", int'(idxD), e.indice);
                checkOutput("ultimo desc", int'(ultD), int'(e.indice == 21));
            end
        end
    endtask

    typedef struct {
        bit inicio;
        bit ciclico;
        bit abortar;
        bit listo;
        bit expValido;
        int expIndice;
        int expSalida;
        bit expHecho;
    } vector_t;

    vector_t vectores [15];

    initial begin
        int hechoCount;
        int hechoCountD;
        int hechoCycle;
        bit prevStall;
        int prevSal;
        int prevIdx;
        int ciclos;

        // Abort / start-priority sequence starting from idle, applied in order.
        vectores[0]  = '{1, 0, 0, 1, 1, 0, 1, 0};
        vectores[1]  = '{0, 0, 0, 1, 1, 1, 2, 0};
        vectores[2]  = '{0, 0, 0, 1, 1, 2, 3, 0};
        vectores[3]  = '{0, 0, 0, 1, 1, 3, 5, 0};
        vectores[4]  = '{0, 0, 0, 1, 1, 4, 10, 0};
        vectores[5]  = '{0, 0, 0, 1, 1, 5, 12, 0};
        vectores[6]  = '{0, 0, 0, 1, 1, 6, 13, 0};
        vectores[7]  = '{0, 0, 0, 1, 1, 7, 15, 0};
        vectores[8]  = '{0, 0, 1, 0, 0, 0, 1, 0};
        vectores[9]  = '{1, 0, 1, 0, 0, 0, 1, 0};
        vectores[10] = '{1, 0, 0, 0, 1, 0, 1, 0};
        vectores[11] = '{1, 0, 0, 1, 1, 1, 2, 0};
        vectores[12] = '{0, 0, 1, 1, 0, 0, 1, 0};
        vectores[13] = '{1, 1, 0, 0, 1, 0, 1, 0};
        vectores[14] = '{0, 0, 1, 0, 0, 0, 1, 0};

        // Reset state.
        Reset = 1'b1;
        applyStimulus(0, 0, 0, 0);
        #12;
        checkOutput("reset salida asc", int'(salA), 1);
        checkOutput("reset salida desc", int'(salD), 53);
        checkOutput("reset valido", int'(valA), 0);
        checkOutput("reset indice", int'(idxA), 0);
        checkOutput("reset ultimo", int'(ultA), 0);
        checkOutput("reset hecho", int'(hechoA), 0);
`ifdef GENERADOR22_AUTOCHEQUEO_EN
        checkOutput("reset error", int'(errA), 0);
`endif
        @(negedge Reloj);
        Reset = 1'b0;
        stepCycle();

        // Single pass at full rate.
        pushPass(22);
        applyStimulus(1, 0, 0, 1);
        stepCycle();
        applyStimulus(0, 0, 0, 1);
        hechoCount  = 0;
        hechoCountD = 0;
        hechoCycle  = 0;
        for (int c = 1; c <= 24; c++) begin
            observe();
            if (hechoA) begin
                hechoCount++;
                hechoCycle = c;
            end
            if (hechoD) hechoCountD++;
            if (c >= 23) checkOutput("valido after pass", int'(valA), 0);
            stepCycle();
        end
        checkOutput("hecho pulses asc", hechoCount, 1);
        checkOutput("hecho cycle", hechoCycle, 23);
        checkOutput("hecho pulses desc", hechoCountD, 1);
        checkOutput("pass leftover asc", qA.size(), 0);
        checkOutput("pass leftover desc", qD.size(), 0);

        // Random backpressure during a single pass.
        pushPass(22);
        applyStimulus(1, 0, 0, 0);
        stepCycle();
        prevStall  = 1'b0;
        prevSal    = 0;
        prevIdx    = 0;
        hechoCount = 0;
        ciclos     = 0;
        while (ciclos < 300 && !(qA.size() == 0 && !valA)) begin
            applyStimulus(0, 0, 0, 1'($urandom_range(0, 1)));
            if (prevStall && valA) begin
                checkOutput("stall salida stable", int'(salA), prevSal);
                checkOutput("stall indice stable", int'(idxA), prevIdx);
            end
            observe();
            prevStall = valA && !Listo;
            prevSal   = int'(salA);
            prevIdx   = int'(idxA);
            stepCycle();
            if (hechoA) hechoCount++;
            ciclos++;
        end
        checkOutput("random leftover asc", qA.size(), 0);
        checkOutput("random leftover desc", qD.size(), 0);
        checkOutput("random valido end", int'(valA), 0);
        checkOutput("random hecho pulses", hechoCount, 1);

        // Cyclic mode: 50 back-to-back transfers with wrap, no Hecho.
        pushPass(50);
        applyStimulus(1, 1, 0, 1);
        stepCycle();
        applyStimulus(0, 0, 0, 1);
        hechoCount = 0;
        for (int c = 0; c < 50; c++) begin
            observe();
            if (hechoA || hechoD) hechoCount++;
            stepCycle();
        end
        checkOutput("cyclic hecho", hechoCount, 0);
        checkOutput("cyclic leftover asc", qA.size(), 0);
        checkOutput("cyclic leftover desc", qD.size(), 0);
        checkOutput("cyclic still valido", int'(valA), 1);
        checkOutput("cyclic indice", int'(idxA), 6);
        applyStimulus(0, 0, 1, 0);
        stepCycle();
        checkOutput("cyclic abort valido", int'(valA), 0);
        checkOutput("cyclic abort indice", int'(idxA), 0);
        checkOutput("cyclic abort hecho", int'(hechoA), 0);

        // Abort and start-priority vectors.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vectores[i].inicio, vectores[i].ciclico,
                          vectores[i].abortar, vectores[i].listo);
            stepCycle();
            checkOutput($sformatf("vec%0d valido", i), int'(valA), int'(vectores[i].expValido));
            checkOutput($sformatf("vec%0d indice", i), int'(idxA), vectores[i].expIndice);
            checkOutput($sformatf("vec%0d salida", i), int'(salA), vectores[i].expSalida);
            checkOutput($sformatf("vec%0d salida desc", i), int'(salD), miembros[21 - vectores[i].expIndice]);
            checkOutput($sformatf("vec%0d hecho", i), int'(hechoA), int'(vectores[i].expHecho));
        end

        // Abort coinciding with the final transfer: transfer counts, no Hecho.
        pushPass(22);
        applyStimulus(1, 0, 0, 1);
        stepCycle();
        applyStimulus(0, 0, 0, 1);
        for (int c = 0; c < 21; c++) begin
            observe();
            stepCycle();
        end
        checkOutput("last ultimo asc", int'(ultA), 1);
        checkOutput("last ultimo desc", int'(ultD), 1);
        checkOutput("last salida desc", int'(salD), 1);
        applyStimulus(0, 0, 1, 1);
        observe();
        stepCycle();
        applyStimulus(0, 0, 0, 0);
        checkOutput("abort last valido", int'(valA), 0);
        checkOutput("abort last hecho", int'(hechoA), 0);
        stepCycle();
        checkOutput("abort last hecho late", int'(hechoA), 0);
        checkOutput("abort last leftover", qA.size(), 0);

        // Asynchronous reset in the middle of a pass.
        applyStimulus(1, 0, 0, 1);
        stepCycle();
        applyStimulus(0, 0, 0, 1);
        for (int c = 0; c < 5; c++) stepCycle();
        checkOutput("pre-reset indice", int'(idxA), 5);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("async reset valido", int'(valA), 0);
        checkOutput("async reset indice", int'(idxA), 0);
        checkOutput("async reset salida asc", int'(salA), 1);
        checkOutput("async reset salida desc", int'(salD), 53);
        @(negedge Reloj);
        Reset = 1'b0;
        applyStimulus(0, 0, 0, 0);
        stepCycle();
        checkOutput("post-reset hecho", int'(hechoA), 0);
        checkOutput("post-reset valido", int'(valA), 0);

`ifdef GENERADOR22_AUTOCHEQUEO_EN
        // Corrupt the table entry at Indice=4 and expect a sticky Error.
        applyStimulus(1, 0, 0, 1);
        stepCycle();
        for (int c = 0; c < 4; c++) stepCycle();
        applyStimulus(0, 0, 0, 0);
        checkOutput("fault indice", int'(idxA), 4);
        force dut.u_tabla.valor_o = 6'd11;
        #1;
        checkOutput("error before edge", int'(errA), 0);
        stepCycle();
        checkOutput("error after edge", int'(errA), 1);
        release dut.u_tabla.valor_o;
        applyStimulus(0, 0, 0, 1);
        for (int c = 0; c < 20; c++) stepCycle();
        checkOutput("error sticky", int'(errA), 1);
        checkOutput("error desc clean", int'(errD), 0);
        Reset = 1'b1;
        #1;
        checkOutput("error cleared", int'(errA), 0);
        @(negedge Reloj);
        Reset = 1'b0;
`endif

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
